// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and the register file it feeds.
// Exposes the FSM state type, requester indices and default address/data widths.
package regfile_write_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int REQ_CORE = 0;
   localparam int REQ_DBG  = 1;

   localparam int DEF_ADDR = 4;
   localparam int DEF_SIZE = 32;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way grant logic: round-robin by default, fixed req0 priority when REGARB_FIXED_PRIO_EN is defined.
// The rr pointer names the requester that wins the next tie; it moves to the loser after every grant.
module rr_arbiter2
   import regfile_write_arbiter_pkg::*;
(
`ifndef REGARB_FIXED_PRIO_EN
   input  logic       clk,
   input  logic       rst,
`endif
   input  logic       en_i,
   input  logic [1:0] valid_i,
   output logic [1:0] ready_o
);

`ifdef REGARB_FIXED_PRIO_EN

   always_comb begin
      ready_o = 2'b00;
      if (en_i) begin
         if (&valid_i) ready_o[REQ_CORE] = 1'b1;
         else          ready_o = valid_i;
      end
   end

`else

   logic rr_q, rr_d;

   always_comb begin
      ready_o = 2'b00;
      rr_d    = rr_q;
      if (en_i) begin
         if (&valid_i) ready_o[rr_q] = 1'b1;
         else          ready_o = valid_i;
      end
      // The loser of this grant gets priority on the next tie.
      if (ready_o[REQ_CORE])     rr_d = 1'(REQ_DBG);
      else if (ready_o[REQ_DBG]) rr_d = 1'(REQ_CORE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end

`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write/PC-load port between core and debug, and runs a zero-all clear pass.
// Tie-break is round-robin unless REGARB_FIXED_PRIO_EN is defined (then req0 always wins).
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int ADDR = DEF_ADDR,
   parameter int NUMB = 1 << ADDR,
   parameter int SIZE = DEF_SIZE
) (
   input  logic            clk,
   input  logic            Rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic            req0_pc,
   input  logic [ADDR-1:0] req0_addr,
   input  logic [SIZE-1:0] req0_data,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic            req1_pc,
   input  logic [ADDR-1:0] req1_addr,
   input  logic [SIZE-1:0] req1_data,
   input  logic            clear_start,
   output logic            Write_Reg,
   output logic [ADDR-1:0] W_Addr,
   output logic [SIZE-1:0] W_Data,
   output logic            Write_PC,
   output logic [SIZE-1:0] PC_New,
   output logic [1:0]      grant,
   output logic            busy,
   output logic            clear_done
);

   localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(NUMB - 1);

   state_e          state_q, state_d;
   logic [ADDR-1:0] cnt_q, cnt_d;
   logic            wreg_q, wreg_d;
   logic [ADDR-1:0] waddr_q, waddr_d;
   logic [SIZE-1:0] wdata_q, wdata_d;
   logic            wpc_q, wpc_d;
   logic [SIZE-1:0] pcnew_q, pcnew_d;
   logic [1:0]      grant_q, grant_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            arbEn;
   logic [1:0]      ready;
   logic            selPc;
   logic [ADDR-1:0] selAddr;
   logic [SIZE-1:0] selData;

   // A clear request in IDLE suppresses any accept in the same cycle.
   assign arbEn = (state_q == IDLE) && !clear_start;

   rr_arbiter2 uArb (
`ifndef REGARB_FIXED_PRIO_EN
      .clk     (clk),
      .rst     (Rst),
`endif
      .en_i    (arbEn),
      .valid_i ({req1_valid, req0_valid}),
      .ready_o (ready)
   );

   assign req0_ready = ready[REQ_CORE];
   assign req1_ready = ready[REQ_DBG];

   assign selPc   = ready[REQ_DBG] ? req1_pc   : req0_pc;
   assign selAddr = ready[REQ_DBG] ? req1_addr : req0_addr;
   assign selData = ready[REQ_DBG] ? req1_data : req0_data;

   // Outputs are computed one cycle ahead so each strobe lines up with its state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wreg_d  = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wpc_d   = 1'b0;
      pcnew_d = pcnew_q;
      grant_d = 2'b00;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clear_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
               wreg_d  = 1'b1;
               waddr_d = '0;
               wdata_d = '0;
               wpc_d   = 1'b1;
               pcnew_d = '0;
               busy_d  = 1'b1;
            end else if (|ready) begin
               grant_d = ready;
               if (selPc) begin
                  wpc_d   = 1'b1;
                  pcnew_d = selData;
               end else begin
                  wreg_d  = 1'b1;
                  waddr_d = selAddr;
                  wdata_d = selData;
               end
            end
         end
         CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               wreg_d  = 1'b1;
               waddr_d = cnt_q + 1'b1;
               wdata_d = '0;
               busy_d  = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wreg_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wpc_q   <= 1'b0;
         pcnew_q <= '0;
         grant_q <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wreg_q  <= wreg_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wpc_q   <= wpc_d;
         pcnew_q <= pcnew_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Write_Reg  = wreg_q;
   assign W_Addr     = waddr_q;
   assign W_Data     = wdata_q;
   assign Write_PC   = wpc_q;
   assign PC_New     = pcnew_q;
   assign grant      = grant_q;
   assign busy       = busy_q;
   assign clear_done = done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter: reset, contention, PC load, clear, abort, back-to-back.
// Expected tie winners follow REGARB_FIXED_PRIO_EN when the bench is built with it.
module tb_regfile_write_arbiter;

`ifdef REGARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        Rst;
   logic        req0_valid, req0_ready, req0_pc;
   logic [3:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req1_valid, req1_ready, req1_pc;
   logic [3:0]  req1_addr;
   logic [31:0] req1_data;
   logic        clear_start;
   logic        Write_Reg, Write_PC, busy, clear_done;
   logic [3:0]  W_Addr;
   logic [31:0] W_Data, PC_New;
   logic [1:0]  grant;

   int checks = 0;
   int failures = 0;

   regfile_write_arbiter #(.ADDR(4), .SIZE(32)) dut (
      .clk(clk), .Rst(Rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .clear_start(clear_start),
      .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
      .Write_PC(Write_PC), .PC_New(PC_New), .grant(grant),
      .busy(busy), .clear_done(clear_done)
   );

   always #5 clk = ~clk;

   // Hard stop in case a later edit leaves the sequence waiting forever.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic v0, input logic pc0, input logic [3:0] a0, input logic [31:0] d0,
                                input logic v1, input logic pc1, input logic [3:0] a1, input logic [31:0] d1,
                                input logic cs);
      req0_valid = v0; req0_pc = pc0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_pc = pc1; req1_addr = a1; req1_data = d1;
      clear_start = cs;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   initial begin
      int win;
      int found;
      logic [3:0]  lastAddr;
      logic [31:0] lastData;

      lastAddr = '0;
      lastData = '0;
      Rst = 1'b1;
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_wreg", Write_Reg, 0);
      checkOutput("rst_wpc", Write_PC, 0);
      checkOutput("rst_grant", grant, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", clear_done, 0);
      Rst = 1'b0;

      // Single request from the debug side, then an async reset with no clock edge.
      applyStimulus(0, 0, 4'd0, 32'd0, 1, 0, 4'd5, 32'hDEADBEEF, 0);
      #1;
      checkOutput("t1_ready1", req1_ready, 1);
      checkOutput("t1_ready0", req0_ready, 0);
      @(posedge clk); #1;
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      checkOutput("t1_wreg", Write_Reg, 1);
      checkOutput("t1_waddr", W_Addr, 5);
      checkOutput("t1_wdata", W_Data, 32'hDEADBEEF);
      checkOutput("t1_grant", grant, 2'b10);
      checkOutput("t1_wpc", Write_PC, 0);
      Rst = 1'b1;
      #1;
      checkOutput("async_wreg", Write_Reg, 0);
      checkOutput("async_waddr", W_Addr, 0);
      checkOutput("async_wdata", W_Data, 0);
      checkOutput("async_grant", grant, 0);
      #1 Rst = 1'b0;

      // Four cycles of contention; rr pointer starts at req0.
      for (int i = 0; i < 4; i++) begin
         win = FIXED ? 0 : (i % 2);
         applyStimulus(1, 0, 4'(i), 32'h1000 + i, 1, 0, 4'(8 + i), 32'h2000 + i, 0);
         #1;
         checkOutput("tie_ready0", req0_ready, (win == 0));
         checkOutput("tie_ready1", req1_ready, (win == 1));
         @(posedge clk); #1;
         lastAddr = (win == 0) ? 4'(i) : 4'(8 + i);
         lastData = (win == 0) ? 32'h1000 + i : 32'h2000 + i;
         checkOutput("tie_wreg", Write_Reg, 1);
         checkOutput("tie_grant", grant, (win == 0) ? 2'b01 : 2'b10);
         checkOutput("tie_waddr", W_Addr, lastAddr);
         checkOutput("tie_wdata", W_Data, lastData);
      end
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      @(posedge clk); #1;
      checkOutput("tie_idle_wreg", Write_Reg, 0);
      checkOutput("tie_idle_grant", grant, 0);

      // PC load leaves the register-write address/data holding.
      applyStimulus(1, 1, 4'd9, 32'h00000040, 0, 0, 4'd0, 32'd0, 0);
      #1;
      checkOutput("pc_ready0", req0_ready, 1);
      @(posedge clk); #1;
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      checkOutput("pc_wpc", Write_PC, 1);
      checkOutput("pc_new", PC_New, 32'h40);
      checkOutput("pc_wreg", Write_Reg, 0);
      checkOutput("pc_grant", grant, 2'b01);
      checkOutput("pc_waddr_hold", W_Addr, lastAddr);
      checkOutput("pc_wdata_hold", W_Data, lastData);
      @(posedge clk); #1;
      checkOutput("pc_wpc_drop", Write_PC, 0);

      // Clear beats a pending req0 in the same cycle.
      applyStimulus(1, 0, 4'd4, 32'h55, 0, 0, 4'd0, 32'd0, 1);
      #1;
      checkOutput("clr_ready0", req0_ready, 0);
      checkOutput("clr_ready1", req1_ready, 0);
      @(posedge clk); #1;
      applyStimulus(1, 0, 4'd4, 32'h55, 0, 0, 4'd0, 32'd0, 0);
      for (int k = 0; k < 16; k++) begin
         checkOutput("clr_wreg", Write_Reg, 1);
         checkOutput("clr_waddr", W_Addr, k);
         checkOutput("clr_wdata", W_Data, 0);
         checkOutput("clr_wpc", Write_PC, (k == 0));
         checkOutput("clr_busy", busy, 1);
         checkOutput("clr_ready0_busy", req0_ready, 0);
         @(posedge clk); #1;
      end
      checkOutput("clr_done", clear_done, 1);
      checkOutput("clr_done_busy", busy, 0);
      checkOutput("clr_done_wreg", Write_Reg, 0);
      checkOutput("clr_done_ready0", req0_ready, 0);
      @(posedge clk); #1;
      checkOutput("clr_done_drop", clear_done, 0);
      checkOutput("clr_after_ready0", req0_ready, 1);
      @(posedge clk); #1;
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      checkOutput("clr_after_wreg", Write_Reg, 1);
      checkOutput("clr_after_waddr", W_Addr, 4);
      checkOutput("clr_after_wdata", W_Data, 32'h55);
      checkOutput("clr_after_grant", grant, 2'b01);

      // Reset in the middle of a clear pass aborts it without a done pulse.
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 1);
      @(posedge clk); #1;
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         if (Write_Reg && W_Addr == 4'd7) found = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      checkOutput("abort_reach7", found, 1);
      Rst = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_wreg", Write_Reg, 0);
      checkOutput("abort_done", clear_done, 0);
      #1 Rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checkOutput("abort_no_done", clear_done, 0);
         checkOutput("abort_idle_busy", busy, 0);
      end
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 1);
      @(posedge clk); #1;
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      checkOutput("restart_waddr", W_Addr, 0);
      checkOutput("restart_wreg", Write_Reg, 1);
      checkOutput("restart_wpc", Write_PC, 1);
      checkOutput("restart_busy", busy, 1);
      repeat (16) @(posedge clk);
      #1;
      checkOutput("restart_done", clear_done, 1);
      @(posedge clk); #1;

      // Back-to-back lone req0 accepts, then a tie to probe where rr was left.
      for (int j = 1; j <= 3; j++) begin
         applyStimulus(1, 0, 4'(j), 32'h300 + j, 0, 0, 4'd0, 32'd0, 0);
         #1;
         checkOutput("b2b_ready0", req0_ready, 1);
         @(posedge clk); #1;
         checkOutput("b2b_wreg", Write_Reg, 1);
         checkOutput("b2b_waddr", W_Addr, j);
         checkOutput("b2b_grant", grant, 2'b01);
      end
      applyStimulus(1, 0, 4'd12, 32'hAAAA, 1, 0, 4'd13, 32'hBBBB, 0);
      #1;
      checkOutput("rr_probe_ready1", req1_ready, !FIXED);
      checkOutput("rr_probe_ready0", req0_ready, FIXED);
      @(posedge clk); #1;
      applyStimulus(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0);
      checkOutput("rr_probe_grant", grant, FIXED ? 2'b01 : 2'b10);
      checkOutput("rr_probe_waddr", W_Addr, FIXED ? 4'd12 : 4'd13);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
